beam_direction_decoder: RTL and testbench

Converts two raw beam-break sensors (A outside, B inside) at the hall doorway into direction-qualified entry and exit strobes for the occupancy lighting top. It sits between the doorway sensor pins and the `entry_sensor`/`exit_sensor` inputs of `top_hall_lighting`. Each output strobe is stretched to a width the top's debouncer accepts. The block synchronises and debounces both beams, tracks the crossing order with a state machine, and queues events so that back-to-back crossings are not merged.

---
 rtl/beam_direction_decoder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_beam_direction_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_direction_decoder.sv
// beam_direction_decoder
//   Turns two raw doorway beam-break sensors into direction-qualified entry
//   and exit strobes. Each beam is synchronised and debounced. A crossing-order
//   FSM then classifies the walk as an entry (A first) or an exit (B first),
//   and a small queue per direction replays events as fixed-width strobes.
//
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   beam_a    in  outer beam, raw/asynchronous, 1 = broken
//   beam_b    in  inner beam, raw/asynchronous, 1 = broken
//   entry_out out stretched entry strobe (PULSE_CYCLES high)
//   exit_out  out stretched exit strobe (PULSE_CYCLES high)
//   busy      out crossing FSM is not idle
//   fault     out one-cycle pulse: ambiguous start, dwell timeout or queue overflow

// Two-flop synchroniser followed by a hold-steady debouncer.
// Ports: clk, rst_n, raw (asynchronous input), level (debounced output).
module beam_debounce #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int unsigned W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] MAX = W'(CYCLES);

    logic         sync1;
    logic         sync2;
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end
endmodule

// Event queue plus strobe sequencer for one direction.
// Ports: clk, rst_n, event_in (one-cycle event), strobe (PULSE_CYCLES high,
// then at least PULSE_CYCLES low), overflow (event dropped this cycle).
module beam_strobe_queue #(
    parameter int unsigned PULSE_CYCLES = 150000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic event_in,
    output logic strobe,
    output logic overflow
);
    localparam int unsigned W = $clog2(PULSE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF,
        HIGH,
        GAP
    } seq_t;

    seq_t         seq;
    seq_t         seq_next;
    logic [W-1:0] width;
    logic [1:0]   pending;
    logic         take;

    always_comb begin
        seq_next = seq;
        take     = 1'b0;
        case (seq)
            OFF: begin
                if (pending != 2'd0) begin
                    seq_next = HIGH;
                    take     = 1'b1;
                end
            end
            HIGH: if (width == LAST) seq_next = GAP;
            GAP:  if (width == LAST) seq_next = OFF;
            default: seq_next = OFF;
        endcase
    end

    // A full queue still accepts an event in the cycle it hands one out.
    assign overflow = event_in && (pending == 2'd3) && !take;
    assign strobe   = (seq == HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq     <= OFF;
            width   <= '0;
            pending <= 2'd0;
        end else begin
            seq <= seq_next;
            if (seq_next != seq || seq == OFF) begin
                width <= '0;
            end else begin
                width <= width + W'(1);
            end
            case ({event_in && !overflow, take})
                2'b10:   pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase
        end
    end
endmodule

module beam_direction_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned PULSE_CYCLES    = 150000,
    parameter int unsigned TIMEOUT_CYCLES  = 200000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beam_a,
    input  logic beam_b,
    output logic entry_out,
    output logic exit_out,
    output logic busy,
    output logic fault
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        A1,
        AB,
        B2,
        B1,
        BA,
        A2,
        CLEAR
    } state_t;

    logic          a;
    logic          b;
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] dwell;
    logic          crossing;
    logic          entry_evt;
    logic          exit_evt;
    logic          ambiguous;
    logic          timeout;
    logic          entry_ovf;
    logic          exit_ovf;

    beam_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (beam_a),
        .level (a)
    );

    beam_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (beam_b),
        .level (b)
    );

    assign crossing = (state != IDLE) && (state != CLEAR);

    always_comb begin
        state_next = state;
        entry_evt  = 1'b0;
        exit_evt   = 1'b0;
        ambiguous  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (a && !b) begin
                    state_next = A1;
                end else if (!a && b) begin
                    state_next = B1;
                end else if (a && b) begin
                    state_next = CLEAR;
                    ambiguous  = 1'b1;
                end
            end
            A1: begin
                if (a && b)        state_next = AB;
                else if (!a && b)  state_next = B2;
                else if (!a && !b) state_next = IDLE;
            end
            AB: begin
                if (!a && b) begin
                    state_next = B2;
                end else if (a && !b) begin
                    state_next = A1;
                end else if (!a && !b) begin
                    state_next = IDLE;
                    entry_evt  = 1'b1;
                end
            end
            B2: begin
                if (!a && !b) begin
                    state_next = IDLE;
                    entry_evt  = 1'b1;
                end else if (a && b) begin
                    state_next = AB;
                end else if (a && !b) begin
                    state_next = A1;
                end
            end
            B1: begin
                if (a && b)        state_next = BA;
                else if (a && !b)  state_next = A2;
                else if (!a && !b) state_next = IDLE;
            end
            BA: begin
                if (a && !b) begin
                    state_next = A2;
                end else if (!a && b) begin
                    state_next = B1;
                end else if (!a && !b) begin
                    state_next = IDLE;
                    exit_evt   = 1'b1;
                end
            end
            A2: begin
                if (!a && !b) begin
                    state_next = IDLE;
                    exit_evt   = 1'b1;
                end else if (a && b) begin
                    state_next = BA;
                end else if (!a && b) begin
                    state_next = B1;
                end
            end
            CLEAR: if (!a && !b) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // An expired dwell overrides whatever the beams asked for this cycle.
        if (crossing && dwell == TO_MAX) begin
            state_next = CLEAR;
            entry_evt  = 1'b0;
            exit_evt   = 1'b0;
            timeout    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dwell <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            if (!crossing || state_next != state) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + TW'(1);
            end
            fault <= ambiguous || timeout || entry_ovf || exit_ovf;
        end
    end

    assign busy = (state != IDLE);

    beam_strobe_queue #(.PULSE_CYCLES(PULSE_CYCLES)) u_entry_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (entry_evt),
        .strobe   (entry_out),
        .overflow (entry_ovf)
    );

    beam_strobe_queue #(.PULSE_CYCLES(PULSE_CYCLES)) u_exit_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (exit_evt),
        .strobe   (exit_out),
        .overflow (exit_ovf)
    );
endmodule

// File: tb/tb_beam_direction_decoder.sv
// Bench for beam_direction_decoder. The main instance uses DEBOUNCE=4,
// PULSE=8, TIMEOUT=64. A second instance with a long strobe (PULSE=48) lets
// crossings arrive faster than strobes drain so the queue can saturate.
module tb_beam_direction_decoder;
    localparam int unsigned QP = 48;

    logic clk = 1'b0;
    logic rst_n;
    logic beam_a, beam_b, entry_out, exit_out, busy, fault;
    logic qa, qb, entry_q, exit_q, busy_q, fault_q;

    int checks = 0;
    int errors = 0;

    int rise_cnt[4], bad_width[4], short_gap[4], hi_len[4], lo_len[4];
    int fault_cnt = 0, fault_q_cnt = 0, fault_long = 0;
    logic fault_prev = 1'b0;

    always #5 clk = ~clk;

    beam_direction_decoder #(
        .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .beam_a(beam_a), .beam_b(beam_b),
        .entry_out(entry_out), .exit_out(exit_out), .busy(busy), .fault(fault)
    );

    beam_direction_decoder #(
        .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(QP), .TIMEOUT_CYCLES(64)
    ) dut_q (
        .clk(clk), .rst_n(rst_n), .beam_a(qa), .beam_b(qb),
        .entry_out(entry_q), .exit_out(exit_q), .busy(busy_q), .fault(fault_q)
    );

    function automatic int pw(input int k);
        return (k >= 2) ? int'(QP) : 8;
    endfunction

    // Strobe shape monitor: counts rising edges, checks high width and low gap.
    always @(negedge clk) begin
        logic [3:0] s;
        s = {exit_q, entry_q, exit_out, entry_out};
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hi_len[k] = 0;
                lo_len[k] = 1000;
            end
            fault_prev = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) begin
                    if (hi_len[k] == 0) begin
                        rise_cnt[k]++;
                        if (lo_len[k] < pw(k)) short_gap[k]++;
                    end
                    hi_len[k]++;
                    lo_len[k] = 0;
                end else begin
                    if (hi_len[k] != 0 && hi_len[k] != pw(k)) bad_width[k]++;
                    hi_len[k] = 0;
                    lo_len[k]++;
                end
            end
            if (fault) fault_cnt++;
            if (fault && fault_prev) fault_long++;
            fault_prev = fault;
            if (fault_q) fault_q_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ab, input int n);
        beam_a = ab[1];
        beam_b = ab[0];
        cyc(n);
    endtask

    // Reference for the queue: strobes start no earlier than one cycle after
    // their event and no earlier than one full period after the previous
    // strobe; an event finding three strobes still waiting is lost.
    function automatic void queue_model(input int n, input int spacing, input int period,
                                        output int shown, output int dropped);
        int starts[$];
        int t, pend, st;
        dropped = 0;
        for (int i = 0; i < n; i++) begin
            t = i * spacing;
            pend = 0;
            foreach (starts[k]) if (starts[k] > t) pend++;
            if (pend >= 3) begin
                dropped++;
            end else begin
                st = t + 1;
                if (starts.size() > 0 && starts[$] + period > st) st = starts[$] + period;
                starts.push_back(st);
            end
        end
        shown = starts.size();
    endfunction

    initial begin
        int e0, x0, f0, lat, busy_seen, exp_shown, exp_drop;
        logic [1:0] cur, first, nxt;
        int start_b, nph;

        for (int k = 0; k < 4; k++) begin
            rise_cnt[k] = 0; bad_width[k] = 0; short_gap[k] = 0;
            hi_len[k] = 0; lo_len[k] = 1000;
        end
        rst_n = 1'b0; beam_a = 1'b0; beam_b = 1'b0; qa = 1'b0; qb = 1'b0;
        cyc(3);
        chk("reset_entry", entry_out, 0);
        chk("reset_exit", exit_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fault", fault, 0);
        chk("reset_q_busy", busy_q, 0);
        rst_n = 1'b1;
        cyc(5);

        // Directed entry: A, A+B, B, clear at 20-cycle spacing.
        e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
        drive(2'b10, 20);
        chk("entry_busy", busy, 1);
        drive(2'b11, 20);
        drive(2'b01, 20);
        beam_b = 1'b0;
        lat = 0;
        while (entry_out !== 1'b1 && lat < 20) begin cyc(1); lat++; end
        chk("entry_rise_seen", entry_out, 1);
        chk("entry_latency_ok", lat <= 12, 1);
        cyc(40);
        chk("entry_count", rise_cnt[0] - e0, 1);
        chk("entry_no_exit", rise_cnt[1] - x0, 0);
        chk("entry_no_fault", fault_cnt - f0, 0);
        chk("entry_idle", busy, 0);

        // Directed exit: mirrored order.
        e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
        drive(2'b01, 20);
        drive(2'b11, 20);
        drive(2'b10, 20);
        drive(2'b00, 40);
        chk("exit_count", rise_cnt[1] - x0, 1);
        chk("exit_no_entry", rise_cnt[0] - e0, 0);
        chk("exit_no_fault", fault_cnt - f0, 0);

        // Back-out: A alone then clear.
        e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
        drive(2'b10, 20);
        drive(2'b00, 40);
        chk("backout_strobes", (rise_cnt[0] - e0) + (rise_cnt[1] - x0), 0);
        chk("backout_fault", fault_cnt - f0, 0);
        chk("backout_idle", busy, 0);

        // Random walks: a crossing counts in the direction of its starting
        // side unless the last occupied position was the starting side alone.
        for (int w = 0; w < 12; w++) begin
            e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
            start_b = int'($urandom_range(0, 1));
            nph = int'($urandom_range(1, 4));
            first = (start_b != 0) ? 2'b01 : 2'b10;
            cur = first;
            drive(cur, int'($urandom_range(8, 25)));
            for (int p = 1; p < nph; p++) begin
                do nxt = 2'($urandom_range(1, 3)); while (nxt == cur);
                cur = nxt;
                drive(cur, int'($urandom_range(8, 25)));
            end
            drive(2'b00, 45);
            chk($sformatf("walk%0d_entry", w), rise_cnt[0] - e0,
                (cur != first && start_b == 0) ? 1 : 0);
            chk($sformatf("walk%0d_exit", w), rise_cnt[1] - x0,
                (cur != first && start_b != 0) ? 1 : 0);
            chk($sformatf("walk%0d_fault", w), fault_cnt - f0, 0);
        end

        // Dwell timeout: A then A+B held for 100 cycles.
        e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
        drive(2'b10, 10);
        drive(2'b11, 100);
        chk("timeout_fault", fault_cnt - f0, 1);
        chk("timeout_clear_busy", busy, 1);
        drive(2'b00, 40);
        chk("timeout_no_strobe", (rise_cnt[0] - e0) + (rise_cnt[1] - x0), 0);
        chk("timeout_idle", busy, 0);

        // Ambiguous start: both beams in the same cycle.
        e0 = rise_cnt[0]; x0 = rise_cnt[1]; f0 = fault_cnt;
        drive(2'b11, 15);
        chk("ambig_fault", fault_cnt - f0, 1);
        chk("ambig_busy", busy, 1);
        drive(2'b00, 40);
        chk("ambig_no_strobe", (rise_cnt[0] - e0) + (rise_cnt[1] - x0), 0);
        chk("ambig_idle", busy, 0);

        // 3-cycle glitch on A must never reach the FSM.
        busy_seen = 0;
        beam_a = 1'b1;
        for (int i = 0; i < 3; i++) begin cyc(1); if (busy) busy_seen++; end
        beam_a = 1'b0;
        for (int i = 0; i < 15; i++) begin cyc(1); if (busy) busy_seen++; end
        chk("glitch_no_busy", busy_seen, 0);

        // Reset during an entry strobe.
        drive(2'b10, 10);
        drive(2'b01, 10);
        beam_b = 1'b0;
        lat = 0;
        while (entry_out !== 1'b1 && lat < 30) begin cyc(1); lat++; end
        chk("rst_strobe_seen", entry_out, 1);
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_entry_low", entry_out, 0);
        chk("rst_busy_low", busy, 0);
        e0 = rise_cnt[0]; x0 = rise_cnt[1];
        cyc(2);
        rst_n = 1'b1;
        cyc(40);
        chk("rst_no_replay", (rise_cnt[0] - e0) + (rise_cnt[1] - x0), 0);

        // Queue saturation on the long-strobe instance: five entries every 18 cycles.
        queue_model(5, 18, 2 * int'(QP) + 1, exp_shown, exp_drop);
        e0 = rise_cnt[2]; f0 = fault_q_cnt;
        for (int i = 0; i < 5; i++) begin
            qa = 1'b1; cyc(6);
            qa = 1'b0; qb = 1'b1; cyc(6);
            qb = 1'b0; cyc(6);
        end
        cyc(450);
        chk("queue_strobes", rise_cnt[2] - e0, exp_shown);
        chk("queue_fault", fault_q_cnt - f0, exp_drop);
        chk("queue_no_exit", rise_cnt[3], 0);
        chk("queue_idle", busy_q, 0);

        chk("width_main", bad_width[0] + bad_width[1], 0);
        chk("width_q", bad_width[2] + bad_width[3], 0);
        chk("gap_all", short_gap[0] + short_gap[1] + short_gap[2] + short_gap[3], 0);
        chk("fault_single_cycle", fault_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
